// File: rtl/fp_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fp_issue_ctrl_pkg
// Shared types for the FP issue controller. The operator, rounding-mode and
// format encodings match fpnew_pkg so that fields pass straight through to
// the FPU. Also holds the controller state encoding, the fflags layout and
// the held-request record.
// -----------------------------------------------------------------------------
package fp_issue_ctrl_pkg;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [2:0] {
        FP32, FP64, FP16, FP8, FP16ALT
    } fp_format_e;

    typedef enum logic [1:0] {
        IDLE, ISSUE, WAIT, WB
    } issue_state_e;

    // Bit order matches the RISC-V fflags CSR: {NV,DZ,OF,UF,NX}.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Op fields held stable towards the FPU while an op is in flight.
    typedef struct packed {
        operation_e op;
        logic       op_mod;
        roundmode_e rm;
        fp_format_e src_fmt;
        fp_format_e dst_fmt;
    } issue_req_t;

    localparam logic [2:0] RM_DYN = 3'b111;

    // Only RNE..RMM are architecturally valid rounding modes after the
    // dynamic field has been resolved.
    function automatic logic rm_is_legal(input logic [2:0] rm);
        return rm < 3'd5;
    endfunction

endpackage

// File: rtl/fp_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// fp_issue_ctrl_if
// Request/response bundle between the issue controller and the fpnew top.
//   in_valid/in_ready    : request handshake (controller -> FPU)
//   operands             : {c,b,a}, FLEN bits each
//   op/op_mod/rm/fmts    : operation descriptor
//   out_valid/out_ready  : response handshake (FPU -> controller)
//   result/status        : FPU result and exception flags {NV,DZ,OF,UF,NX}
// master = issue controller, slave = FPU.
// -----------------------------------------------------------------------------
interface fp_issue_ctrl_if
    import fp_issue_ctrl_pkg::*;
#(
    parameter int unsigned FLEN = 32
) ();

    logic              in_valid;
    logic              in_ready;
    logic [3*FLEN-1:0] operands;
    operation_e        op;
    logic              op_mod;
    roundmode_e        rm;
    fp_format_e        src_fmt;
    fp_format_e        dst_fmt;
    logic              out_valid;
    logic              out_ready;
    logic [FLEN-1:0]   result;
    fflags_t           status;

    modport master (
        output in_valid, operands, op, op_mod, rm, src_fmt, dst_fmt, out_ready,
        input  in_ready, out_valid, result, status
    );

    modport slave (
        input  in_valid, operands, op, op_mod, rm, src_fmt, dst_fmt, out_ready,
        output in_ready, out_valid, result, status
    );

endinterface

// File: rtl/fp_issue_ctrl_rm_resolve.sv
// -----------------------------------------------------------------------------
// fp_issue_ctrl_rm_resolve
// Combinational rounding-mode resolution.
//   rm_i    : instruction rm field
//   frm_i   : fcsr.frm, used when rm_i selects the dynamic mode
//   rm_o    : effective rounding mode
//   legal_o : effective mode is one of RNE..RMM
// -----------------------------------------------------------------------------
module fp_issue_ctrl_rm_resolve
    import fp_issue_ctrl_pkg::*;
(
    input  roundmode_e rm_i,
    input  logic [2:0] frm_i,
    output roundmode_e rm_o,
    output logic       legal_o
);

    always_comb begin
        rm_o    = (rm_i == RM_DYN) ? roundmode_e'(frm_i) : rm_i;
        legal_o = rm_is_legal(rm_o);
    end

endmodule

// File: rtl/fp_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fp_issue_ctrl
// Issues one decoded FP op at a time to fpnew, waits for its result, writes
// it back to the FP or integer register file and accumulates fflags. The core
// is stalled while an op is in flight.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   dec_*_i                  : decoded op from fp_decoder
//   rs_a_i/rs_b_i/rs_c_i     : FP register-file read data
//   frm_i                    : fcsr.frm for dynamic rounding
//   fpu                      : request/response bundle to fpnew (master side)
//   fp_wb_*_o / int_wb_*_o   : register-file write ports, one-cycle enables
//   fflags_o / fflags_clr_i  : sticky flags and their CSR clear
//   stall_o                  : core stall
//   illegal_rm_o             : pulse when the resolved rounding mode is invalid
// -----------------------------------------------------------------------------
module fp_issue_ctrl
    import fp_issue_ctrl_pkg::*;
#(
    parameter int unsigned FLEN = 32,
    parameter int unsigned XLEN = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    // decoder side
    input  logic               dec_valid_i,
    input  operation_e         dec_op_i,
    input  logic               dec_op_mod_i,
    input  roundmode_e         dec_rm_i,
    input  fp_format_e         dec_src_fmt_i,
    input  fp_format_e         dec_dst_fmt_i,
    input  logic [4:0]         dec_waddr_i,
    input  logic               dec_fp_wr_i,
    input  logic               dec_int_wr_i,
    input  logic [FLEN-1:0]    rs_a_i,
    input  logic [FLEN-1:0]    rs_b_i,
    input  logic [FLEN-1:0]    rs_c_i,
    input  logic [2:0]         frm_i,
    // fpnew side
    fp_issue_ctrl_if.master    fpu,
    // register-file writeback
    output logic               fp_wb_en_o,
    output logic [4:0]         fp_wb_addr_o,
    output logic [FLEN-1:0]    fp_wb_data_o,
    output logic               int_wb_en_o,
    output logic [4:0]         int_wb_addr_o,
    output logic [XLEN-1:0]    int_wb_data_o,
    // CSR / core control
    output logic [4:0]         fflags_o,
    input  logic               fflags_clr_i,
    output logic               stall_o,
    output logic               illegal_rm_o
);

    issue_state_e      state_q, state_d;
    issue_req_t        req_q;
    logic [3*FLEN-1:0] operands_q;
    logic [4:0]        waddr_q;
    logic              fp_wr_q, int_wr_q;
    logic [FLEN-1:0]   result_q;
    fflags_t           status_q;
    fflags_t           fflags_q, fflags_d;

    roundmode_e        rm_res;
    logic              rm_legal;
    logic              accept;      // capture a decoded op this cycle
    logic              capture;     // capture the FPU response this cycle
    logic              wb;          // writeback cycle
    logic              in_valid;
    logic              out_ready;
    logic              stall;
    logic              illegal_rm;

    fp_issue_ctrl_rm_resolve u_rm_resolve (
        .rm_i    (dec_rm_i),
        .frm_i   (frm_i),
        .rm_o    (rm_res),
        .legal_o (rm_legal)
    );

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d    = state_q;
        accept     = 1'b0;
        capture    = 1'b0;
        wb         = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        stall      = 1'b1;
        illegal_rm = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = 1'b0;
                if (dec_valid_i) begin
                    if (rm_legal) begin
                        // Stall in the accept cycle itself so the decoder
                        // does not advance past the op being captured.
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        illegal_rm = 1'b1;
                    end
                end
            end
            ISSUE: begin
                in_valid = 1'b1;
                if (fpu.in_ready) begin
                    if (fpu.out_valid) begin
                        // Zero-latency op: take the result in the handshake cycle.
                        out_ready = 1'b1;
                        capture   = 1'b1;
                        state_d   = WB;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                out_ready = 1'b1;
                if (fpu.out_valid) begin
                    capture = 1'b1;
                    state_d = WB;
                end
            end
            WB: begin
                // Released here so the next op is accepted the cycle after WB.
                wb      = 1'b1;
                stall   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    // NOTE: the held request/result registers are reset along with the state
    // so every output, including the operand bus, reads 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q      <= '0;
            operands_q <= '0;
            waddr_q    <= '0;
            fp_wr_q    <= 1'b0;
            int_wr_q   <= 1'b0;
        end else if (accept) begin
            req_q      <= '{op:      dec_op_i,
                            op_mod:  dec_op_mod_i,
                            rm:      rm_res,
                            src_fmt: dec_src_fmt_i,
                            dst_fmt: dec_dst_fmt_i};
            operands_q <= {rs_c_i, rs_b_i, rs_a_i};
            waddr_q    <= dec_waddr_i;
            fp_wr_q    <= dec_fp_wr_i;
            int_wr_q   <= dec_int_wr_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q <= '0;
            status_q <= '0;
        end else if (capture) begin
            result_q <= fpu.result;
            status_q <= fpu.status;
        end
    end

    // A CSR clear coinciding with writeback keeps only the new status.
    always_comb begin
        fflags_d = fflags_q;
        if (fflags_clr_i) fflags_d = '0;
        if (wb)           fflags_d = fflags_t'(fflags_d | status_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fflags_q <= '0;
        else         fflags_q <= fflags_d;
    end

    // ------------------------------------------------------------- outputs
    assign fpu.in_valid  = in_valid;
    assign fpu.out_ready = out_ready;
    assign fpu.operands  = operands_q;
    assign fpu.op        = req_q.op;
    assign fpu.op_mod    = req_q.op_mod;
    assign fpu.rm        = req_q.rm;
    assign fpu.src_fmt   = req_q.src_fmt;
    assign fpu.dst_fmt   = req_q.dst_fmt;

    assign fp_wb_en_o    = wb & fp_wr_q;
    assign fp_wb_addr_o  = waddr_q;
    assign fp_wb_data_o  = result_q;
    assign int_wb_en_o   = wb & int_wr_q;
    assign int_wb_addr_o = waddr_q;

    if (XLEN > FLEN) begin : g_int_zext
        assign int_wb_data_o = {{(XLEN-FLEN){1'b0}}, result_q};
    end else begin : g_int_low
        assign int_wb_data_o = result_q[XLEN-1:0];
    end

    assign fflags_o      = fflags_q;
    assign stall_o       = stall;
    assign illegal_rm_o  = illegal_rm;

endmodule
